// File: rtl/repeat_line_emitter.sv
// Parses newline-terminated "[sel][digits]" command lines from a byte stream and
// emits the selected character N times (plus optional newline) over a busy/en handshake.
module repeat_line_emitter #(
    parameter int unsigned COUNT_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [7:0]  DEFAULT_CHAR = 8'h42,
    parameter bit          EMIT_NEWLINE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       input_valid,
    input  logic [7:0] input_data,
    input  logic       output_busy,
    output logic       output_en,
    output logic [7:0] output_data,
    output logic       overflow,
    output logic       parse_error
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_PARSE  = 3'd0;
    localparam logic [2:0] S_SEND   = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_NL     = 3'd3;
    localparam logic [2:0] S_NL_GAP = 3'd4;

    logic [7:0]             fifo_mem_r [FIFO_DEPTH];
    logic [AW:0]            wr_ptr_r;
    logic [AW:0]            rd_ptr_r;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic                   wr_en_s;
    logic                   pop_s;
    logic                   overflow_r;

    logic [2:0]             state_r;
    logic [COUNT_WIDTH-1:0] count_r;
    logic [COUNT_WIDTH-1:0] run_r;
    logic [7:0]             emit_char_r;
    logic [7:0]             run_char_r;
    logic                   started_r;
    logic                   bad_r;
    logic                   parse_error_r;

    logic [7:0]             byte_s;
    logic                   is_digit_s;
    logic                   is_cr_s;
    logic                   is_lf_s;
    logic                   is_sel_s;
    logic [COUNT_WIDTH+3:0] acc_s;
    logic [COUNT_WIDTH-1:0] count_next_s;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                          (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign wr_en_s      = input_valid && !fifo_full_s;
    assign pop_s        = (state_r == S_PARSE) && !fifo_empty_s;

    assign byte_s       = fifo_mem_r[rd_ptr_r[AW-1:0]];
    assign is_digit_s   = (byte_s >= 8'h30) && (byte_s <= 8'h39);
    assign is_cr_s      = (byte_s == 8'h0D);
    assign is_lf_s      = (byte_s == 8'h0A);
    assign is_sel_s     = (byte_s >= 8'h21) && (byte_s <= 8'h7E) && !is_digit_s;

    // count*10 + digit in a 4-bit-wider accumulator; any carry out means saturation,
    // and an all-ones count always carries out again, so saturation is sticky per line.
    assign acc_s        = ({4'd0, count_r} << 3) + ({4'd0, count_r} << 1) +
                          {{COUNT_WIDTH{1'b0}}, byte_s[3:0]};
    assign count_next_s = (acc_s[COUNT_WIDTH+3:COUNT_WIDTH] != 4'd0) ?
                          {COUNT_WIDTH{1'b1}} : acc_s[COUNT_WIDTH-1:0];

    // FIFO storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            fifo_mem_r[wr_ptr_r[AW-1:0]] <= input_data;
        end
    end

    // FIFO pointers and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (input_valid && fifo_full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Line parser and emission sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_PARSE;
            count_r       <= '0;
            run_r         <= '0;
            emit_char_r   <= DEFAULT_CHAR;
            run_char_r    <= DEFAULT_CHAR;
            started_r     <= 1'b0;
            bad_r         <= 1'b0;
            parse_error_r <= 1'b0;
        end else begin
            parse_error_r <= 1'b0;
            case (state_r)
                S_PARSE: begin
                    if (pop_s) begin
                        if (is_lf_s) begin
                            count_r     <= '0;
                            emit_char_r <= DEFAULT_CHAR;
                            started_r   <= 1'b0;
                            bad_r       <= 1'b0;
                            if (bad_r) begin
                                parse_error_r <= 1'b1;
                            end else if (count_r != '0) begin
                                run_r      <= count_r;
                                run_char_r <= emit_char_r;
                                state_r    <= S_SEND;
                            end
                        end else if (!is_cr_s && !bad_r) begin
                            if (is_digit_s) begin
                                count_r   <= count_next_s;
                                started_r <= 1'b1;
                            end else if (is_sel_s && !started_r) begin
                                emit_char_r <= byte_s;
                                started_r   <= 1'b1;
                            end else begin
                                bad_r <= 1'b1;
                            end
                        end
                    end
                end
                S_SEND: begin
                    if (!output_busy) begin
                        run_r   <= run_r - COUNT_WIDTH'(1);
                        state_r <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (!output_busy) begin
                        if (run_r != '0) begin
                            state_r <= S_SEND;
                        end else if (EMIT_NEWLINE) begin
                            state_r <= S_NL;
                        end else begin
                            state_r <= S_PARSE;
                        end
                    end
                end
                S_NL: begin
                    if (!output_busy) begin
                        state_r <= S_NL_GAP;
                    end
                end
                S_NL_GAP: begin
                    if (!output_busy) begin
                        state_r <= S_PARSE;
                    end
                end
                default: begin
                    state_r <= S_PARSE;
                end
            endcase
        end
    end

    // Strobe is combinational on output_busy so a byte goes out the first idle cycle.
    always_comb begin
        output_en   = 1'b0;
        output_data = 8'h00;
        case (state_r)
            S_SEND: begin
                if (!output_busy) begin
                    output_en   = 1'b1;
                    output_data = run_char_r;
                end else begin
                    output_en   = 1'b0;
                    output_data = 8'h00;
                end
            end
            S_NL: begin
                if (!output_busy) begin
                    output_en   = 1'b1;
                    output_data = 8'h0A;
                end else begin
                    output_en   = 1'b0;
                    output_data = 8'h00;
                end
            end
            default: begin
                output_en   = 1'b0;
                output_data = 8'h00;
            end
        endcase
    end

    assign overflow    = overflow_r;
    assign parse_error = parse_error_r;

endmodule

// File: tb/tb_repeat_line_emitter.sv
// Directed bench for repeat_line_emitter (COUNT_WIDTH=4, FIFO_DEPTH=4):
// collects output strobes at negedge and compares against hand-written strings.
module tb_repeat_line_emitter;

    logic       clk = 1'b0;
    logic       rst;
    logic       input_valid;
    logic [7:0] input_data;
    logic       output_busy;
    logic       output_en;
    logic [7:0] output_data;
    logic       overflow;
    logic       parse_error;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         last_cyc = 0;
    int         perr_cnt = 0;
    logic       prev_en = 1'b0;
    logic [7:0] out_q [$];
    int         out_cyc [$];

    repeat_line_emitter #(
        .COUNT_WIDTH (4),
        .FIFO_DEPTH  (4),
        .DEFAULT_CHAR(8'h42),
        .EMIT_NEWLINE(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .input_valid(input_valid),
        .input_data (input_data),
        .output_busy(output_busy),
        .output_en  (output_en),
        .output_data(output_data),
        .overflow   (overflow),
        .parse_error(parse_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe monitor: records every emitted byte and guards the handshake rules.
    always @(negedge clk) begin
        if (output_en) begin
            check("en_while_busy", {31'd0, output_busy}, 32'd0);
            check("back_to_back", {31'd0, prev_en}, 32'd0);
            out_q.push_back(output_data);
            out_cyc.push_back(cyc);
        end
        if (parse_error) perr_cnt <= perr_cnt + 1;
        prev_en <= output_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            input_valid = 1'b1;
            input_data  = s[i];
            last_cyc    = cyc;
            tick();
        end
        input_valid = 1'b0;
        input_data  = 8'h00;
    endtask

    task automatic wait_strobes(input string tag, input int base, input int n, input int budget);
        int k = 0;
        while ((out_q.size() - base) < n && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_timeout"}, {31'd0, (out_q.size() - base) >= n}, 32'd1);
    endtask

    task automatic expect_out(input string tag, input int base, input string exp);
        check({tag, "_len"}, out_q.size() - base, exp.len());
        for (int i = 0; i < exp.len() && (base + i) < out_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), {24'd0, out_q[base + i]}, {24'd0, exp[i]});
        end
    endtask

    initial begin
        int base;
        int pbase;
        string s;

        rst         = 1'b1;
        input_valid = 1'b0;
        input_data  = 8'h00;
        output_busy = 1'b0;
        repeat (3) tick();
        check("rst_en", {31'd0, output_en}, 32'd0);
        check("rst_data", {24'd0, output_data}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_perr", {31'd0, parse_error}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic run with latency and spacing
        base  = out_q.size();
        pbase = perr_cnt;
        send_str("3\n");
        wait_strobes("basic", base, 4, 40);
        repeat (10) tick();
        expect_out("basic", base, "BBB\n");
        if (out_q.size() - base >= 4) begin
            check("basic_first_lat", out_cyc[base], last_cyc + 2);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("basic_gap%0d", i), out_cyc[base + i + 1] - out_cyc[base + i], 32'd2);
            end
        end
        check("basic_ovf", {31'd0, overflow}, 32'd0);
        check("basic_perr", perr_cnt - pbase, 32'd0);

        // Selector, two digits, carriage return
        base = out_q.size();
        send_str("x12\015\n");
        wait_strobes("sel", base, 13, 100);
        repeat (10) tick();
        expect_out("sel", base, "xxxxxxxxxxxx\n");

        // Zero count emits nothing
        base = out_q.size();
        send_str("0\n");
        repeat (20) tick();
        check("zero_none", out_q.size() - base, 32'd0);

        // Saturation at 15 with COUNT_WIDTH=4
        base = out_q.size();
        send_str("99\n");
        wait_strobes("sat", base, 16, 100);
        repeat (10) tick();
        expect_out("sat", base, "BBBBBBBBBBBBBBB\n");

        // Error recovery
        base  = out_q.size();
        pbase = perr_cnt;
        send_str("1a2\n4\n");
        wait_strobes("err", base, 5, 60);
        repeat (10) tick();
        check("err_perr_once", perr_cnt - pbase, 32'd1);
        expect_out("err", base, "BBBB\n");

        // Backpressure: queued lines come out in order after release
        base        = out_q.size();
        output_busy = 1'b1;
        send_str("2\n2\n");
        repeat (46) tick();
        check("bp_no_strobe", out_q.size() - base, 32'd0);
        output_busy = 1'b0;
        wait_strobes("bp", base, 6, 80);
        repeat (10) tick();
        expect_out("bp", base, "BB\nBB\n");
        check("bp_ovf", {31'd0, overflow}, 32'd0);

        // Overflow: one line parked in SEND, then six bytes into a 4-deep FIFO
        base        = out_q.size();
        output_busy = 1'b1;
        send_str("1\n");
        repeat (3) tick();
        send_str("1\n1\n1\n");
        repeat (3) tick();
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_no_strobe", out_q.size() - base, 32'd0);
        output_busy = 1'b0;
        wait_strobes("ovf", base, 6, 80);
        repeat (20) tick();
        expect_out("ovf", base, "B\nB\nB\n");

        // Reset mid-emission abandons the run and clears overflow
        base = out_q.size();
        send_str("5\n");
        wait_strobes("rstmid", base, 2, 40);
        rst = 1'b1;
        tick();
        check("rstmid_en", {31'd0, output_en}, 32'd0);
        check("rstmid_ovf", {31'd0, overflow}, 32'd0);
        check("rstmid_data", {24'd0, output_data}, 32'd0);
        rst  = 1'b0;
        base = out_q.size();
        repeat (30) tick();
        check("rstmid_quiet", out_q.size() - base, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/repeat_line_emitter.md
Name: repeat_line_emitter

Overview:
- Successor to the single-digit repeat block: parses newline-terminated command lines from the byte input stream and emits a selected character N times on the byte output port.
- Generalisations: multi-digit decimal counts, selectable emit character, optional trailing newline, and an input FIFO so input bytes arriving during emission are kept.
- Sits between the UART receive byte stream and the UART transmit interface (busy/en handshake).

Parameters:
- COUNT_WIDTH, 16, width of the repeat counter; parsed counts saturate at 2^COUNT_WIDTH-1.
- FIFO_DEPTH, 16, input FIFO entries; power of two, >= 2.
- DEFAULT_CHAR, 8'h42 ("B"), emit character when a line carries no selector.
- EMIT_NEWLINE, 1, if 1 then append 8'h0A after each non-zero emission run.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- input_valid  input  1  input_data valid this cycle (one byte per pulse, no backpressure)
- input_data  input  8  received byte
- output_busy  input  1  transmitter busy with a previous byte
- output_en  output  1  one-cycle strobe: send output_data
- output_data  output  8  byte to send; meaningful only when output_en=1
- overflow  output  1  sticky: an input byte was dropped because the FIFO was full
- parse_error  output  1  one-cycle pulse when a line is rejected

Behaviour:
- Reset: synchronous, active-high, on the clk edge. Outputs after reset: output_en=0, output_data=0, overflow=0, parse_error=0. FIFO is emptied and the FSM goes to PARSE with line state cleared. Reset in any state, including mid-emission, abandons the run; no further strobes are issued.
- FIFO write:
  - Byte is written when input_valid=1 and the FIFO is not full, with fullness taken from occupancy at the start of the cycle.
  - If full, the byte is dropped and overflow is set, even if a pop happens in the same cycle.
- FIFO read: a byte written at edge t is poppable by the parser from cycle t+1. The parser pops at most one byte per cycle, only in PARSE.
- Line grammar, with bytes processed in order:
  - The first byte of a line may be a selector: any byte in 0x21..0x7E that is not a digit "0".."9". It latches the emit character. With no selector, the emit character is DEFAULT_CHAR.
  - Digits accumulate as count = count*10 + digit. If the result exceeds 2^COUNT_WIDTH-1, count saturates at all-ones and stays there for the rest of the line.
  - 8'h0D is ignored anywhere in a line.
  - 8'h0A terminates the line.
  - Any other byte, or a second selector, marks the line bad. The rest of the line through 8'h0A is discarded. parse_error pulses for one cycle on the terminating 8'h0A pop. No emission occurs for a bad line.
- FSM states: PARSE, SEND, GAP, NL, NL_GAP.
  - PARSE: pop and process bytes. On a good 8'h0A with count>0: load the counter and go to SEND next cycle. With count=0, or no digits: emit nothing and stay in PARSE. Line state clears after every 8'h0A.
  - SEND: output_en is combinational. output_en=1 and output_data=emit character in the same cycle that output_busy=0. On that edge the counter decrements and the FSM goes to GAP. While output_busy=1, hold.
  - GAP: wait until output_busy=0 for at least one cycle, then:
    - to SEND if counter>0;
    - else to NL if EMIT_NEWLINE=1;
    - else to PARSE.
  - NL: strobe 8'h0A when output_busy=0, then go to NL_GAP.
  - NL_GAP: wait for output_busy=0, then go to PARSE.
- Throughput: with output_busy held 0, strobes occur every 2 cycles. Back-to-back output_en is never allowed.
- Bytes arriving during SEND/GAP/NL are queued in the FIFO, not lost, unless the FIFO is full.
- output_en is never asserted while output_busy=1.

Test Plan:
- Basic run:
  - stimulus: after reset send "3\n" with output_busy=0;
  - required: exactly "BBB\n" on output_en strobes, 2 cycles apart;
  - required: first strobe in the cycle after the 8'h0A is popped;
  - required: overflow=0, parse_error=0.
- Selector + multi-digit + CR:
  - stimulus: "x12\r\n";
  - required: 12 strobes of 8'h78 then 8'h0A;
  - stimulus: then "0\n";
  - required: no strobes.
- Saturation:
  - stimulus: COUNT_WIDTH=4, "99\n";
  - required: 15 emitted characters then newline.
- Error recovery:
  - stimulus: "1a2\n4\n";
  - required: parse_error pulses once on the first 8'h0A;
  - required: then "BBBB\n" only.
- Backpressure + FIFO:
  - stimulus: output_busy held 1 for 50 cycles while "2\n2\n" arrives;
  - required: no strobes during busy;
  - required: after release, "BB\nBB\n" in order.
- Overflow + reset:
  - stimulus: FIFO_DEPTH=4, output_busy=1, 6 bytes "1\n1\n1\n";
  - required: overflow=1 and the last 2 bytes dropped;
  - stimulus: assert rst mid-emission;
  - required: output_en=0 on the next cycle and overflow=0.
